alu_issue_sched: RTL and testbench

//  Reservation station and issue scheduler for the single RV32I ALU in the OoO core.
//  - Buffers dispatched ALU uops and captures operands via CDB wakeup.
//  - Each cycle, issues the oldest uop with both operands ready to the combinational ALU.
//  - Registers the ALU result into a 1-entry output buffer; valid/ready handshake toward the CDB arbiter.

---
 rtl/alu_issue_sched_if.sv | 59 +++++
 rtl/alu_issue_sched.sv | 149 ++++++++++++++
 tb/tb_alu_issue_sched.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_sched_if.sv
// Signal bundle between the ALU reservation station and its neighbours:
// dispatch, CDB broadcast, the combinational ALU and the CDB arbiter.
interface alu_issue_sched_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush;

    logic             disp_valid;
    logic             disp_ready;
    logic [3:0]       disp_op;
    logic [TAG_W-1:0] disp_tag;
    logic             disp_a_rdy;
    logic [31:0]      disp_a_val;
    logic [TAG_W-1:0] disp_a_tag;
    logic             disp_b_rdy;
    logic [31:0]      disp_b_val;
    logic [TAG_W-1:0] disp_b_tag;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;

    logic [3:0]       alu_op;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_result;

    logic             res_valid;
    logic             res_ready;
    logic [TAG_W-1:0] res_tag;
    logic [31:0]      res_data;

    logic [CNT_W-1:0] rs_count;

    modport slave (
        input  flush,
        input  disp_valid, disp_op, disp_tag,
        input  disp_a_rdy, disp_a_val, disp_a_tag,
        input  disp_b_rdy, disp_b_val, disp_b_tag,
        input  cdb_valid, cdb_tag, cdb_data,
        input  alu_result, res_ready,
        output disp_ready, alu_op, alu_a, alu_b,
        output res_valid, res_tag, res_data, rs_count
    );

    modport master (
        output flush,
        output disp_valid, disp_op, disp_tag,
        output disp_a_rdy, disp_a_val, disp_a_tag,
        output disp_b_rdy, disp_b_val, disp_b_tag,
        output cdb_valid, cdb_tag, cdb_data,
        output alu_result, res_ready,
        input  disp_ready, alu_op, alu_a, alu_b,
        input  res_valid, res_tag, res_data, rs_count
    );
endinterface

// File: rtl/alu_issue_sched.sv
// ALU reservation station: buffers dispatched uops, wakes operands off the CDB,
// issues the oldest ready uop to the ALU and holds its result for the CDB arbiter.
module alu_issue_sched #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_sched_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic             valid;
        logic [3:0]       op;
        logic [TAG_W-1:0] tag;
        logic             a_rdy;
        logic [31:0]      a_val;
        logic [TAG_W-1:0] a_tag;
        logic             b_rdy;
        logic [31:0]      b_val;
        logic [TAG_W-1:0] b_tag;
    } entry_t;

    entry_t           ent_q   [DEPTH];
    entry_t           ent_d   [DEPTH];
    // older_q[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    logic             res_valid_q, res_valid_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [DEPTH-1:0] rdy_vec;
    logic             disp_ready, can_issue, issue, issue_fire, alloc;
    logic [IDX_W-1:0] iss_idx, free_idx;

    assign disp_ready = (count_q != CNT_W'(DEPTH));
    assign can_issue  = !res_valid_q || bus.res_ready;
    assign alloc      = bus.disp_valid && disp_ready && !bus.flush;
    assign issue_fire = issue && !bus.flush;

    always_comb begin
        rdy_vec  = '0;
        issue    = 1'b0;
        iss_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec[i] = ent_q[i].valid && ent_q[i].a_rdy && ent_q[i].b_rdy;
        end
        // The oldest ready entry is the one older than every other ready entry
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy_vec[i] && (((older_q[i] | (DEPTH'(1) << i)) & rdy_vec) == rdy_vec)) begin
                issue   = can_issue;
                iss_idx = IDX_W'(i);
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        ent_d       = ent_q;
        older_d     = older_q;
        res_valid_d = res_valid_q;
        res_tag_d   = res_tag_q;
        res_data_d  = res_data_q;
        count_d     = count_q + CNT_W'(alloc) - CNT_W'(issue_fire);

        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && !ent_q[i].a_rdy && bus.cdb_valid && (ent_q[i].a_tag == bus.cdb_tag)) begin
                ent_d[i].a_rdy = 1'b1;
                ent_d[i].a_val = bus.cdb_data;
            end
            if (ent_q[i].valid && !ent_q[i].b_rdy && bus.cdb_valid && (ent_q[i].b_tag == bus.cdb_tag)) begin
                ent_d[i].b_rdy = 1'b1;
                ent_d[i].b_val = bus.cdb_data;
            end
        end

        if (issue_fire) begin
            ent_d[iss_idx].valid = 1'b0;
            res_valid_d          = 1'b1;
            res_tag_d            = ent_q[iss_idx].tag;
            res_data_d           = bus.alu_result;
        end else if (bus.res_ready) begin
            res_valid_d = 1'b0;
        end

        // A dispatching operand may be satisfied by the CDB broadcast of the same cycle
        if (alloc) begin
            ent_d[free_idx].valid = 1'b1;
            ent_d[free_idx].op    = bus.disp_op;
            ent_d[free_idx].tag   = bus.disp_tag;
            ent_d[free_idx].a_rdy = bus.disp_a_rdy || (bus.cdb_valid && (bus.cdb_tag == bus.disp_a_tag));
            ent_d[free_idx].a_val = bus.disp_a_rdy ? bus.disp_a_val : bus.cdb_data;
            ent_d[free_idx].a_tag = bus.disp_a_tag;
            ent_d[free_idx].b_rdy = bus.disp_b_rdy || (bus.cdb_valid && (bus.cdb_tag == bus.disp_b_tag));
            ent_d[free_idx].b_val = bus.disp_b_rdy ? bus.disp_b_val : bus.cdb_data;
            ent_d[free_idx].b_tag = bus.disp_b_tag;
            for (int j = 0; j < DEPTH; j++) begin
                older_d[j][free_idx] = 1'b1;
            end
            older_d[free_idx] = '0;
        end

        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
            res_valid_d = 1'b0;
            count_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i]   <= '0;
                older_q[i] <= '0;
            end
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_data_q  <= '0;
            count_q     <= '0;
        end else begin
            ent_q       <= ent_d;
            older_q     <= older_d;
            res_valid_q <= res_valid_d;
            res_tag_q   <= res_tag_d;
            res_data_q  <= res_data_d;
            count_q     <= count_d;
        end
    end

    assign bus.disp_ready = disp_ready;
    assign bus.alu_op     = issue ? ent_q[iss_idx].op    : 4'd0;
    assign bus.alu_a      = issue ? ent_q[iss_idx].a_val : 32'd0;
    assign bus.alu_b      = issue ? ent_q[iss_idx].b_val : 32'd0;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_tag    = res_tag_q;
    assign bus.res_data   = res_data_q;
    assign bus.rs_count   = count_q;
endmodule

// File: tb/tb_alu_issue_sched.sv
// Self-checking bench for alu_issue_sched: ALU vector table, directed corner sequences
// and randomized traffic compared every cycle against a dispatch-ordered queue model.
module tb_alu_issue_sched;
    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_issue_sched_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();
    alu_issue_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return {31'd0, $signed(a) < $signed(b)};
            4'd4:    return {31'd0, a < b};
            4'd5:    return a ^ b;
            4'd6:    return a >> b[4:0];
            4'd7:    return $signed(a) >>> b[4:0];
            4'd8:    return a | b;
            4'd9:    return a & b;
            default: return 32'd0;
        endcase
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

    typedef struct {
        logic [3:0]       op;
        logic [TAG_W-1:0] tag;
        logic             a_rdy;
        logic [31:0]      a_val;
        logic [TAG_W-1:0] a_tag;
        logic             b_rdy;
        logic [31:0]      b_val;
        logic [TAG_W-1:0] b_tag;
    } uop_t;

    typedef struct {
        logic             disp_valid;
        uop_t             u;
        logic             cdb_valid;
        logic [TAG_W-1:0] cdb_tag;
        logic [31:0]      cdb_data;
        logic             res_ready;
        logic             flush;
    } stim_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    // Reference model: pending uops kept in dispatch order, oldest at the front
    uop_t             mq[$];
    logic             m_res_valid = 1'b0;
    logic [TAG_W-1:0] m_res_tag   = '0;
    logic [31:0]      m_res_data  = '0;
    stim_t            cur;
    int               checks = 0;
    int               errors = 0;

    function automatic int oldest_ready();
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].a_rdy && mq[i].b_rdy) return i;
        end
        return -1;
    endfunction

    function automatic uop_t mk_uop(input int op, input int tag, input int a_rdy, input logic [31:0] a_val,
                                    input int a_tag, input int b_rdy, input logic [31:0] b_val, input int b_tag);
        uop_t u;
        u.op    = 4'(op);
        u.tag   = TAG_W'(tag);
        u.a_rdy = (a_rdy != 0);
        u.a_val = a_val;
        u.a_tag = TAG_W'(a_tag);
        u.b_rdy = (b_rdy != 0);
        u.b_val = b_val;
        u.b_tag = TAG_W'(b_tag);
        return u;
    endfunction

    function automatic stim_t idle(input logic rr);
        stim_t s;
        s.disp_valid = 1'b0;
        s.u          = mk_uop(0, 0, 1, 32'd0, 0, 1, 32'd0, 0);
        s.cdb_valid  = 1'b0;
        s.cdb_tag    = '0;
        s.cdb_data   = '0;
        s.res_ready  = rr;
        s.flush      = 1'b0;
        return s;
    endfunction

    function automatic stim_t disp(input uop_t u, input logic rr);
        stim_t s;
        s            = idle(rr);
        s.disp_valid = 1'b1;
        s.u          = u;
        return s;
    endfunction

    function automatic stim_t cdb(input int tag, input logic [31:0] data, input logic rr);
        stim_t s;
        s           = idle(rr);
        s.cdb_valid = 1'b1;
        s.cdb_tag   = TAG_W'(tag);
        s.cdb_data  = data;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.disp_valid = ($urandom_range(0, 1) == 1);
        s.u.op       = 4'($urandom_range(0, 15));
        s.u.tag      = TAG_W'($urandom_range(0, 31));
        s.u.a_rdy    = ($urandom_range(0, 2) != 0);
        s.u.a_val    = $urandom;
        s.u.a_tag    = TAG_W'($urandom_range(0, 7));
        s.u.b_rdy    = ($urandom_range(0, 2) != 0);
        s.u.b_val    = $urandom;
        s.u.b_tag    = TAG_W'($urandom_range(0, 7));
        s.cdb_valid  = ($urandom_range(0, 9) < 4);
        s.cdb_tag    = TAG_W'($urandom_range(0, 7));
        s.cdb_data   = $urandom;
        s.res_ready  = ($urandom_range(0, 9) < 7);
        s.flush      = ($urandom_range(0, 99) == 0);
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input stim_t s);
        bus.disp_valid = s.disp_valid;
        bus.disp_op    = s.u.op;
        bus.disp_tag   = s.u.tag;
        bus.disp_a_rdy = s.u.a_rdy;
        bus.disp_a_val = s.u.a_val;
        bus.disp_a_tag = s.u.a_tag;
        bus.disp_b_rdy = s.u.b_rdy;
        bus.disp_b_val = s.u.b_val;
        bus.disp_b_tag = s.u.b_tag;
        bus.cdb_valid  = s.cdb_valid;
        bus.cdb_tag    = s.cdb_tag;
        bus.cdb_data   = s.cdb_data;
        bus.res_ready  = s.res_ready;
        bus.flush      = s.flush;
    endtask

    task automatic checkOutput();
        int          idx;
        logic [3:0]  e_op;
        logic [31:0] e_a, e_b;
        idx  = oldest_ready();
        e_op = '0;
        e_a  = '0;
        e_b  = '0;
        if ((!m_res_valid || cur.res_ready) && idx >= 0) begin
            e_op = mq[idx].op;
            e_a  = mq[idx].a_val;
            e_b  = mq[idx].b_val;
        end
        chk("disp_ready", 32'(bus.disp_ready), 32'(mq.size() != DEPTH));
        chk("rs_count",   32'(bus.rs_count),   32'(mq.size()));
        chk("res_valid",  32'(bus.res_valid),  32'(m_res_valid));
        chk("res_tag",    32'(bus.res_tag),    32'(m_res_tag));
        chk("res_data",   bus.res_data,        m_res_data);
        chk("alu_op",     32'(bus.alu_op),     32'(e_op));
        chk("alu_a",      bus.alu_a,           e_a);
        chk("alu_b",      bus.alu_b,           e_b);
    endtask

    task automatic modelReset();
        mq.delete();
        m_res_valid = 1'b0;
        m_res_tag   = '0;
        m_res_data  = '0;
    endtask

    task automatic modelEdge(input stim_t s);
        int   idx;
        bit   full;
        uop_t u;
        if (s.flush) begin
            mq.delete();
            m_res_valid = 1'b0;
            return;
        end
        full = (mq.size() == DEPTH);
        idx  = oldest_ready();
        if ((!m_res_valid || s.res_ready) && idx >= 0) begin
            m_res_valid = 1'b1;
            m_res_tag   = mq[idx].tag;
            m_res_data  = alu_fn(mq[idx].op, mq[idx].a_val, mq[idx].b_val);
            mq.delete(idx);
        end else if (s.res_ready) begin
            m_res_valid = 1'b0;
        end
        for (int i = 0; i < mq.size(); i++) begin
            u = mq[i];
            if (s.cdb_valid && !u.a_rdy && u.a_tag == s.cdb_tag) begin u.a_rdy = 1'b1; u.a_val = s.cdb_data; end
            if (s.cdb_valid && !u.b_rdy && u.b_tag == s.cdb_tag) begin u.b_rdy = 1'b1; u.b_val = s.cdb_data; end
            mq[i] = u;
        end
        if (s.disp_valid && !full) begin
            u = s.u;
            if (!u.a_rdy && s.cdb_valid && u.a_tag == s.cdb_tag) begin u.a_rdy = 1'b1; u.a_val = s.cdb_data; end
            if (!u.b_rdy && s.cdb_valid && u.b_tag == s.cdb_tag) begin u.b_rdy = 1'b1; u.b_val = s.cdb_data; end
            mq.push_back(u);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        cur = s;
        drive(s);
        #1;
        checkOutput();
        @(posedge clk);
        modelEdge(s);
        #1;
    endtask

    initial begin
        vec_t vecs [12];
        vecs[0]  = '{4'd0,  32'd5,        32'd7,        32'd12};
        vecs[1]  = '{4'd0,  32'hFFFFFFFF, 32'd1,        32'd0};
        vecs[2]  = '{4'd1,  32'd3,        32'd5,        32'hFFFFFFFE};
        vecs[3]  = '{4'd2,  32'd1,        32'd33,       32'd2};
        vecs[4]  = '{4'd3,  32'hFFFFFFFF, 32'd0,        32'd1};
        vecs[5]  = '{4'd4,  32'hFFFFFFFF, 32'd0,        32'd0};
        vecs[6]  = '{4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
        vecs[7]  = '{4'd6,  32'h80000000, 32'd4,        32'h08000000};
        vecs[8]  = '{4'd7,  32'h80000000, 32'd4,        32'hF8000000};
        vecs[9]  = '{4'd8,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0};
        vecs[10] = '{4'd9,  32'h12345678, 32'h0000FFFF, 32'h00005678};
        vecs[11] = '{4'd12, 32'd5,        32'd7,        32'd0};

        rst_n = 1'b0;
        cur   = idle(1'b0);
        drive(cur);
        #12;
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;

        // ALU vector table: dispatch ready, result two edges later
        for (int i = 0; i < 12; i++) begin
            applyStimulus(disp(mk_uop(int'(vecs[i].op), 16 + i, 1, vecs[i].a, 0, 1, vecs[i].b, 0), 1'b1));
            applyStimulus(idle(1'b1));
            chk("vec res_valid", 32'(bus.res_valid), 32'd1);
            chk("vec res_data", bus.res_data, vecs[i].exp);
        end
        applyStimulus(idle(1'b1));

        applyStimulus(disp(mk_uop(0, 3, 1, 32'd5, 0, 1, 32'd7, 0), 1'b1));
        chk("t1 res_valid early", 32'(bus.res_valid), 32'd0);
        applyStimulus(idle(1'b1));
        chk("t1 res_valid", 32'(bus.res_valid), 32'd1);
        chk("t1 res_tag", 32'(bus.res_tag), 32'd3);
        chk("t1 res_data", bus.res_data, 32'd12);

        applyStimulus(disp(mk_uop(1, 4, 1, 32'd10, 0, 0, 32'd0, 9), 1'b1));
        for (int i = 0; i < 2; i++) begin
            applyStimulus(idle(1'b1));
            chk("t2 no early issue", 32'(bus.res_valid), 32'd0);
        end
        applyStimulus(cdb(9, 32'd2, 1'b1));
        chk("t2 no issue on wake", 32'(bus.res_valid), 32'd0);
        applyStimulus(idle(1'b1));
        chk("t2 res_valid", 32'(bus.res_valid), 32'd1);
        chk("t2 res_tag", 32'(bus.res_tag), 32'd4);
        chk("t2 res_data", bus.res_data, 32'd8);
        applyStimulus(idle(1'b1));

        for (int k = 0; k < 4; k++) begin
            applyStimulus(disp(mk_uop(0, 10 + k, 1, k, 0, 1, 32'd100, 0), 1'b0));
        end
        chk("t3 rs_count", 32'(bus.rs_count), 32'd3);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(idle(1'b0));
            chk("t3 held tag", 32'(bus.res_tag), 32'd10);
            chk("t3 held data", bus.res_data, 32'd100);
        end
        applyStimulus(disp(mk_uop(0, 14, 1, 32'd4, 0, 1, 32'd100, 0), 1'b0));
        chk("t3 full disp_ready", 32'(bus.disp_ready), 32'd0);
        applyStimulus(disp(mk_uop(0, 15, 1, 32'd5, 0, 1, 32'd100, 0), 1'b0));
        chk("t3 refused rs_count", 32'(bus.rs_count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(idle(1'b1));
            chk("t3 b2b valid", 32'(bus.res_valid), 32'd1);
            chk("t3 b2b tag", 32'(bus.res_tag), 32'(11 + k));
        end
        applyStimulus(idle(1'b1));
        chk("t3 drained", 32'(bus.res_valid), 32'd0);

        begin
            stim_t s;
            s             = disp(mk_uop(7, 7, 0, 32'd0, 6, 1, 32'd4, 0), 1'b1);
            s.cdb_valid   = 1'b1;
            s.cdb_tag     = TAG_W'(6);
            s.cdb_data    = 32'hFFFFFFFF;
            applyStimulus(s);
        end
        applyStimulus(idle(1'b1));
        chk("t4 res_tag", 32'(bus.res_tag), 32'd7);
        chk("t4 res_data", bus.res_data, 32'hFFFFFFFF);
        applyStimulus(idle(1'b1));

        // Older entry lands in slot 2, younger reuses slot 0; both wake together
        applyStimulus(disp(mk_uop(0, 21, 0, 32'd0, 28, 1, 32'd1, 0), 1'b1));
        applyStimulus(disp(mk_uop(0, 22, 0, 32'd0, 31, 1, 32'd1, 0), 1'b1));
        applyStimulus(disp(mk_uop(0, 23, 0, 32'd0, 30, 1, 32'd3, 0), 1'b1));
        applyStimulus(cdb(28, 32'd100, 1'b1));
        applyStimulus(idle(1'b1));
        applyStimulus(disp(mk_uop(0, 24, 0, 32'd0, 30, 1, 32'd5, 0), 1'b1));
        applyStimulus(cdb(30, 32'd7, 1'b1));
        applyStimulus(idle(1'b1));
        chk("t5 older first tag", 32'(bus.res_tag), 32'd23);
        chk("t5 older first data", bus.res_data, 32'd10);
        applyStimulus(idle(1'b1));
        chk("t5 younger second tag", 32'(bus.res_tag), 32'd24);
        chk("t5 younger second data", bus.res_data, 32'd12);
        applyStimulus(cdb(31, 32'd0, 1'b1));
        applyStimulus(idle(1'b1));
        applyStimulus(idle(1'b1));

        for (int k = 0; k < 4; k++) begin
            applyStimulus(disp(mk_uop(0, 1 + k, 1, k, 0, 1, 32'd1, 0), 1'b0));
        end
        chk("t6 pre rs_count", 32'(bus.rs_count), 32'd3);
        chk("t6 pre res_valid", 32'(bus.res_valid), 32'd1);
        begin
            stim_t s;
            s       = disp(mk_uop(0, 9, 1, 32'd1, 0, 1, 32'd1, 0), 1'b1);
            s.flush = 1'b1;
            applyStimulus(s);
        end
        chk("t6 flush res_valid", 32'(bus.res_valid), 32'd0);
        chk("t6 flush rs_count", 32'(bus.rs_count), 32'd0);
        chk("t6 flush disp_ready", 32'(bus.disp_ready), 32'd1);
        applyStimulus(idle(1'b1));

        applyStimulus(disp(mk_uop(0, 5, 1, 32'd3, 0, 1, 32'd4, 0), 1'b0));
        applyStimulus(disp(mk_uop(0, 6, 1, 32'd3, 0, 1, 32'd4, 0), 1'b0));
        cur = idle(1'b0);
        drive(cur);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        chk("async res_valid", 32'(bus.res_valid), 32'd0);
        chk("async res_tag", 32'(bus.res_tag), 32'd0);
        chk("async res_data", bus.res_data, 32'd0);
        chk("async rs_count", 32'(bus.rs_count), 32'd0);
        chk("async disp_ready", 32'(bus.disp_ready), 32'd1);
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 1500; n++) begin
            applyStimulus(rand_stim());
        end
        begin
            stim_t s;
            s       = idle(1'b1);
            s.flush = 1'b1;
            applyStimulus(s);
        end
        applyStimulus(idle(1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
